// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the Nios debug-slave blocks.
// JDO field positions and the ocimem access state encoding.
package nios_dbg_pkg;

  localparam int unsigned JDO_RDGO      = 34;
  localparam int unsigned JDO_ERRCLR    = 35;
  localparam int unsigned JDO_ADDR_LSB  = 17;
  localparam int unsigned JDO_WDATA_LSB = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } ocimem_state_e;

endpackage

// File: rtl/nios_dbg_rdlat_ctr.sv
// Debug RAM read-latency countdown.
// Raises capture in the cycle the RAM read data is valid.
module nios_dbg_rdlat_ctr #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic active,
  output logic capture
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= 2'(RD_LAT);
    end else if (active && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign capture = active && (cnt == 2'd0);

endmodule

// File: rtl/nios_dbg_ocimem_ctrl.sv
// Debug-memory access controller behind the debug-slave sysclk stage.
// Runs host reads/writes on the debug RAM and reports ready/error.
module nios_dbg_ocimem_ctrl
  import nios_dbg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_e state;
  ocimem_state_e state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata_q;
  logic [31:0]       mon_q;
  logic              rd_q;
  logic              err_q;

  logic idle;
  logic any_cmd;
  logic multi;
  logic go_a;
  logic go_b;
  logic go_na;
  logic rd_start;
  logic err_set;
  logic err_clr;
  logic capture;
  logic unused_jdo;

  wire a  = take_action_ocimem_a;
  wire b  = take_action_ocimem_b;
  wire na = take_no_action_ocimem_a;

  assign unused_jdo = ^jdo;

  assign idle    = (state == IDLE);
  assign any_cmd = a | b | na;
  assign multi   = (a & b) | (a & na) | (b & na);

  // Priority b > a > no_action; losers are dropped.
  assign go_b  = idle & b;
  assign go_a  = idle & a & ~b;
  assign go_na = idle & na & ~a & ~b;

  assign rd_start = (go_a & jdo[JDO_RDGO]) | go_na;
  assign err_set  = (~idle & any_cmd) | (idle & multi);
  assign err_clr  = go_a & jdo[JDO_ERRCLR];

  nios_dbg_rdlat_ctr #(
    .RD_LAT (RD_LAT)
  ) u_rdlat (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (rd_start),
    .active  (state == RD_WAIT),
    .capture (capture)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (go_b) begin
          state_nxt = WR;
        end else if (rd_start) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (capture) begin
          state_nxt = IDLE;
        end
      end
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    monitor_ready = (state == IDLE);
    ram_wr        = (state == WR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr    <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      mon_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      rd_q <= rd_start;
      if (go_a) begin
        addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (capture || state == WR) begin
        addr <= addr + ADDR_W'(1);
      end
      if (go_b) begin
        wdata_q <= jdo[JDO_WDATA_LSB +: 32];
      end
      if (capture) begin
        mon_q <= ram_rdata;
      end
      // A new error in the same cycle beats a clear.
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign ram_addr      = addr;
  assign ram_rd        = rd_q;
  assign ram_wdata     = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_nios_dbg_ocimem_ctrl.sv
// Directed bench for the debug-memory access controller.
// A behavioural RAM with RD_LAT read latency sits behind the DUT.
module tb_nios_dbg_ocimem_ctrl;

  localparam int ADDR_W = 8;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [37:0]       jdo = '0;
  logic              sa = 1'b0;
  logic              sb = 1'b0;
  logic              sn = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic              ram_wr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  logic [31:0] mem [256];
  logic [31:0] pipe [RD_LAT];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  nios_dbg_ocimem_ctrl #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (sa),
    .take_action_ocimem_b    (sb),
    .take_no_action_ocimem_a (sn),
    .ram_addr                (ram_addr),
    .ram_rd                  (ram_rd),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    pipe[0] <= ram_rd ? mem[ram_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (ram_rd && ram_wr) begin
        fails++;
        $display("FAIL rd_wr_excl: ram_rd=%b ram_wr=%b required not both", ram_rd, ram_wr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_a(input logic [7:0] ad, input logic go, input logic clr);
    jdo = '0;
    jdo[17 +: 8] = ad;
    jdo[34] = go;
    jdo[35] = clr;
    sa = 1'b1;
    step();
    sa = 1'b0;
  endtask

  task automatic cmd_b(input logic [31:0] d);
    jdo = '0;
    jdo[3 +: 32] = d;
    sb = 1'b1;
    step();
    sb = 1'b0;
  endtask

  task automatic cmd_n();
    sn = 1'b1;
    step();
    sn = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (monitor_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", monitor_ready); end
    checks++; if (monitor_error !== 1'b0) begin fails++; $display("FAIL rst_error: got %b want 0", monitor_error); end
    checks++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
    checks++; if (ram_rd !== 1'b0 || ram_wr !== 1'b0) begin fails++; $display("FAIL rst_strobes: rd=%b wr=%b want 0 0", ram_rd, ram_wr); end
    checks++; if (ram_addr !== 8'h00) begin fails++; $display("FAIL rst_addr: got %h want 00", ram_addr); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    mem[8'h10] = 32'hDEADBEEF;
    cmd_a(8'h10, 1'b1, 1'b0);
    checks++; if (ram_rd !== 1'b1 || ram_addr !== 8'h10) begin fails++; $display("FAIL rd_issue: rd=%b addr=%h want 1 10", ram_rd, ram_addr); end
    checks++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL rd_busy: ready=%b want 0", monitor_ready); end
    repeat (RD_LAT) step();
    checks++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL rd_early_ready: ready=%b want 0", monitor_ready); end
    step();
    checks++; if (monitor_ready !== 1'b1) begin fails++; $display("FAIL rd_ready: ready=%b want 1", monitor_ready); end
    checks++; if (MonDReg !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", MonDReg); end
    checks++; if (ram_addr !== 8'h11) begin fails++; $display("FAIL rd_incr: got %h want 11", ram_addr); end
  endtask

  task automatic test_wrap_write();
    logic [7:0] ad;
    cmd_a(8'hFE, 1'b0, 1'b0);
    checks++; if (monitor_ready !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== 8'hFE) begin fails++; $display("FAIL ld_addr: ready=%b rd=%b addr=%h want 1 0 fe", monitor_ready, ram_rd, ram_addr); end
    for (int i = 1; i <= 3; i++) begin
      ad = 8'hFE + 8'(i - 1);
      cmd_b(32'(i));
      checks++; if (ram_wr !== 1'b1 || ram_wdata !== 32'(i) || ram_addr !== ad) begin fails++; $display("FAIL wr_issue%0d: wr=%b d=%h a=%h want 1 %h %h", i, ram_wr, ram_wdata, ram_addr, i, ad); end
      checks++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL wr_busy%0d: ready=%b want 0", i, monitor_ready); end
      step();
      checks++; if (monitor_ready !== 1'b1 || ram_wr !== 1'b0) begin fails++; $display("FAIL wr_done%0d: ready=%b wr=%b want 1 0", i, monitor_ready, ram_wr); end
    end
    checks++; if (mem[8'hFE] !== 32'h1) begin fails++; $display("FAIL wr_fe: got %h want 1", mem[8'hFE]); end
    checks++; if (mem[8'hFF] !== 32'h2) begin fails++; $display("FAIL wr_ff: got %h want 2", mem[8'hFF]); end
    checks++; if (mem[8'h00] !== 32'h3) begin fails++; $display("FAIL wr_wrap: got %h want 3", mem[8'h00]); end
    checks++; if (ram_addr !== 8'h01 || monitor_error !== 1'b0) begin fails++; $display("FAIL wr_end: addr=%h err=%b want 01 0", ram_addr, monitor_error); end
  endtask

  task automatic test_overrun();
    mem[8'h40] = 32'h12345678;
    cmd_a(8'h40, 1'b1, 1'b0);
    cmd_n();
    checks++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b0) begin fails++; $display("FAIL ovr_err: err=%b ready=%b want 1 0", monitor_error, monitor_ready); end
    repeat (RD_LAT - 1) begin
      step();
      checks++; if (ram_rd !== 1'b0 || monitor_ready !== 1'b0) begin fails++; $display("FAIL ovr_wait: rd=%b ready=%b want 0 0", ram_rd, monitor_ready); end
    end
    step();
    checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h12345678) begin fails++; $display("FAIL ovr_data: ready=%b data=%h want 1 12345678", monitor_ready, MonDReg); end
    checks++; if (ram_addr !== 8'h41 || monitor_error !== 1'b1) begin fails++; $display("FAIL ovr_state: addr=%h err=%b want 41 1", ram_addr, monitor_error); end
    cmd_a(8'h41, 1'b0, 1'b1);
    checks++; if (monitor_error !== 1'b0) begin fails++; $display("FAIL err_clr: got %b want 0", monitor_error); end
  endtask

  task automatic test_collision();
    logic [31:0] wd;
    cmd_a(8'h20, 1'b0, 1'b0);
    jdo = '0;
    jdo[17 +: 8] = 8'h55;
    jdo[34] = 1'b1;
    jdo[35] = 1'b1;
    wd = jdo[34:3];
    sa = 1'b1;
    sb = 1'b1;
    step();
    sa = 1'b0;
    sb = 1'b0;
    checks++; if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== 8'h20) begin fails++; $display("FAIL col_wr: wr=%b rd=%b a=%h want 1 0 20", ram_wr, ram_rd, ram_addr); end
    checks++; if (ram_wdata !== wd || monitor_error !== 1'b1) begin fails++; $display("FAIL col_data: d=%h err=%b want %h 1", ram_wdata, monitor_error, wd); end
    step();
    checks++; if (mem[8'h20] !== wd || ram_addr !== 8'h21) begin fails++; $display("FAIL col_end: mem=%h a=%h want %h 21", mem[8'h20], ram_addr, wd); end
    checks++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b1) begin fails++; $display("FAIL col_flags: ready=%b err=%b want 1 1", monitor_ready, monitor_error); end
  endtask

  task automatic test_reset_mid();
    mem[8'h30] = 32'hCAFEF00D;
    cmd_a(8'h30, 1'b1, 1'b1);
    cmd_n();
    reset_n = 1'b0;
    #1;
    checks++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b1) begin fails++; $display("FAIL mid_rst: data=%h ready=%b want 0 1", MonDReg, monitor_ready); end
    checks++; if (monitor_error !== 1'b0 || ram_rd !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 8'h00) begin fails++; $display("FAIL mid_rst_out: err=%b rd=%b wr=%b a=%h want 0 0 0 00", monitor_error, ram_rd, ram_wr, ram_addr); end
    step();
    reset_n = 1'b1;
    repeat (RD_LAT + 2) begin
      step();
      checks++; if (ram_rd !== 1'b0 || ram_wr !== 1'b0 || MonDReg !== 32'h0 || monitor_ready !== 1'b1) begin fails++; $display("FAIL mid_after: rd=%b wr=%b data=%h ready=%b want 0 0 0 1", ram_rd, ram_wr, MonDReg, monitor_ready); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_read();
    test_wrap_write();
    test_overrun();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
